// File: rtl/ws2812_write.sv
// rtl/ws2812_write.sv - WS2812 single-wire bit serialiser, one data bit per fixed bit period
module ws2812_write #(
    parameter int T0H_CYC = 20,
    parameter int T1H_CYC = 45,
    parameter int BIT_CYC = 64,
    parameter int CNT_W   = 7
) (
    input  logic clk,
    input  logic rst,
    input  logic value,
    output logic out
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIT_CYC - 1);
    localparam logic [CNT_W-1:0] T0H      = CNT_W'(T0H_CYC);
    localparam logic [CNT_W-1:0] T1H      = CNT_W'(T1H_CYC);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] high_len;
    logic             val_q, val_d;
    logic             out_q, out_d;

    always_comb begin
        cnt_inc  = cnt_q + CNT_W'(1);
        high_len = val_q ? T1H : T0H;
        cnt_d    = cnt_inc;
        val_d    = val_q;
        out_d    = (cnt_inc < high_len);
        // Period boundary: latch the next bit and start its high pulse immediately.
        if (cnt_q == LAST_CNT) begin
            cnt_d = '0;
            val_d = value;
            out_d = 1'b1;
        end
    end

    // Reset parks the counter on the last cycle so the first edge after release opens a bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= LAST_CNT;
            val_q <= 1'b0;
            out_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            val_q <= val_d;
            out_q <= out_d;
        end
    end

    assign out = out_q;

endmodule

// File: tb/tb_ws2812_write.sv
// tb/tb_ws2812_write.sv - randomized self-checking bench for ws2812_write, default and small parameter sets
module tb_ws2812_write;

    logic clk = 1'b0;
    logic rst_a = 1'b1, value_a = 1'b0, out_a;
    logic rst_b = 1'b1, value_b = 1'b0, out_b;
    int   errors = 0;
    int   checks = 0;

    // Timing of each instance: index 0 = default set, 1 = small set
    int t0h_tab [2] = '{20, 3};
    int t1h_tab [2] = '{45, 6};
    int bit_tab [2] = '{64, 10};

    always #5 clk = ~clk;

    ws2812_write u_dut_a (
        .clk   (clk),
        .rst   (rst_a),
        .value (value_a),
        .out   (out_a)
    );

    ws2812_write #(
        .T0H_CYC (3),
        .T1H_CYC (6),
        .BIT_CYC (10),
        .CNT_W   (4)
    ) u_dut_b (
        .clk   (clk),
        .rst   (rst_b),
        .value (value_b),
        .out   (out_b)
    );

    function automatic logic get_out(input int sel);
        return (sel == 0) ? out_a : out_b;
    endfunction

    task automatic set_value(input int sel, input logic v);
        if (sel == 0) value_a = v;
        else          value_b = v;
    endtask

    task automatic set_rst(input int sel, input logic r);
        if (sel == 0) rst_a = r;
        else          rst_b = r;
    endtask

    // Plays a list of bits from the current negedge. The reference is the WS2812 waveform itself:
    // each period begins with the bit presented before its first edge, high for that bit's
    // pulse length and low for the remainder. noise: 0 none, 1 random value every mid-period
    // cycle, 2 invert value just before edge 10 of the period.
    task automatic play_bits(input int sel, input logic bits[$], input int noise, input string tag);
        int   h;
        int   hi_cnt;
        logic exp_lvl;
        for (int p = 0; p < bits.size(); p++) begin
            set_value(sel, bits[p]);
            set_rst(sel, 1'b0);
            h      = bits[p] ? t1h_tab[sel] : t0h_tab[sel];
            hi_cnt = 0;
            for (int j = 0; j < bit_tab[sel]; j++) begin
                @(negedge clk);
                exp_lvl = (j < h);
                checks++;
                if (get_out(sel) !== exp_lvl) begin
                    errors++;
                    $display("FAIL %s level inst=%0d period=%0d cycle=%0d out=%b expected=%b",
                             tag, sel, p, j, get_out(sel), exp_lvl);
                end
                if (get_out(sel) === 1'b1) hi_cnt++;
                if (j < bit_tab[sel] - 1) begin
                    if (noise == 1) set_value(sel, 1'($urandom_range(0, 1)));
                    if (noise == 2 && j == 9) set_value(sel, ~bits[p]);
                end
            end
            checks++;
            if (hi_cnt != h) begin
                errors++;
                $display("FAIL %s pulse_width inst=%0d period=%0d high=%0d expected=%0d",
                         tag, sel, p, hi_cnt, h);
            end
        end
    endtask

    task automatic enter_reset(input int sel, input int cycles);
        set_rst(sel, 1'b1);
        for (int i = 0; i < cycles; i++) @(negedge clk);
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if (out_a !== 1'b0 || out_b !== 1'b0) begin
            errors++;
            $display("FAIL reset_initial out_a=%b out_b=%b expected=0", out_a, out_b);
        end
        for (int i = 0; i < 2500; i++) begin
            @(negedge clk);
            value_a = ~value_a;
            value_b = 1'($urandom_range(0, 1));
            checks++;
            if (out_a !== 1'b0 || out_b !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold cycle=%0d out_a=%b out_b=%b expected=0", i, out_a, out_b);
            end
        end
    endtask

    task automatic test_const(input int sel, input logic v);
        logic bits[$];
        for (int i = 0; i < 4; i++) bits.push_back(v);
        play_bits(sel, bits, 0, v ? "const_one" : "const_zero");
        enter_reset(sel, 3);
    endtask

    task automatic test_alternate(input int sel);
        logic bits[$] = '{1'b1, 1'b0, 1'b1};
        play_bits(sel, bits, 2, "alternate");
        enter_reset(sel, 3);
    endtask

    task automatic test_random(input int sel, input int n);
        logic bits[$];
        for (int i = 0; i < n; i++) bits.push_back(1'($urandom_range(0, 1)));
        play_bits(sel, bits, 1, "random");
        enter_reset(sel, 3);
    endtask

    task automatic test_midbit_reset(input int sel, input int stop);
        logic bits[$];
        logic first;
        set_value(sel, 1'b1);
        set_rst(sel, 1'b0);
        for (int j = 0; j < stop; j++) begin
            @(negedge clk);
            checks++;
            if (get_out(sel) !== (j < t1h_tab[sel])) begin
                errors++;
                $display("FAIL midbit_pre inst=%0d cycle=%0d out=%b expected=%b",
                         sel, j, get_out(sel), (j < t1h_tab[sel]));
            end
        end
        set_rst(sel, 1'b1);
        #1;
        checks++;
        if (get_out(sel) !== 1'b0) begin
            errors++;
            $display("FAIL midbit_async inst=%0d out=%b expected=0", sel, get_out(sel));
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (get_out(sel) !== 1'b0) begin
            errors++;
            $display("FAIL midbit_hold inst=%0d out=%b expected=0", sel, get_out(sel));
        end
        first = 1'($urandom_range(0, 1));
        bits.push_back(first);
        bits.push_back(~first);
        play_bits(sel, bits, 1, "after_midbit");
        enter_reset(sel, 3);
    endtask

    initial begin
        test_reset();
        for (int s = 0; s < 2; s++) begin
            test_const(s, 1'b0);
            test_const(s, 1'b1);
            test_alternate(s);
            test_midbit_reset(s, (s == 0) ? 30 : 4);
            test_random(s, 12);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
